conv_layer_seq: RTL
===================

Name: conv_layer_seq

Overview:
- Layer-level sequencer that generates the convolution dataflow control signals consumed by the utilization monitor and the datapath.
- Signals generated: layer_start/done, dataflow_en, conv_vld, the w/h/ic/oc row counters, weight and input load requests, and the DMA start/last strobes.
- Walks a row-based 3x3, pad-1 loop nest: oc outer, then h, then ic, then w inner.
- Sits between the top-level layer scheduler and the weight buffer, input loader, conv array and output DMA.

Parameters:
- CNT_W, 16, width of size inputs and loop counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a layer; sampled only in IDLE
- cfg_w, cfg_h, cfg_ic, cfg_oc  in  CNT_W each  layer dimensions; latched on accepted start
- stall  in  1  datapath backpressure; freezes CONV
- weight_ack  in  1  weight buffer has loaded the current oc tile
- input_ack  in  1  input loader has delivered row (ic,h)
- dma_done  in  1  output row written
- layer_start  out  1  pulse, cycle after start accepted
- layer_done  out  1  pulse on exit from DONE
- busy  out  1  high whenever state != IDLE
- dataflow_en  out  1  high in CONV when stall=0
- conv_vld  out  9  per-tap valid, bit = ky*3+kx
- w_cnt, h_cnt, ic_cnt, oc_cnt  out  CNT_W each  current loop indices
- weight_req  out  1  level request, held until weight_ack
- input_loader_req  out  1  level request, held until input_ack
- dma_start  out  1  one-cycle pulse per completed output row
- dma_last  out  1  coincident with dma_start for the final row of the layer

Behaviour:
- Reset (async, rstn=0): state IDLE; every output 0; all counters 0; latched cfg 0.
- States: IDLE, WLOAD, ILOAD, CONV, WRITE, DONE.
- IDLE
  - start=1: latch cfg, clear counters, pulse layer_start, go to WLOAD.
  - If any cfg field is 0: go to DONE instead; no requests issued.
  - start in any other state is ignored.
- WLOAD: weight_req=1. When weight_ack=1 (sampled at the clock edge), deassert the request and go to ILOAD next cycle. One handshake per oc tile.
- ILOAD: input_loader_req=1 until input_ack=1, then go to CONV.
- CONV
  - If stall=0: dataflow_en=1, conv_vld=mask(w,h), w_cnt increments.
  - If stall=1: dataflow_en=0, conv_vld=0, all counters hold.
  - On the final beat (w=W-1): w clears.
    - If ic<IC-1: ic++, go to ILOAD.
    - Else: ic clears, go to WRITE.
- conv_vld mask: start from 9'h1FF.
  - w==0: clear bits 0,3,6. w==W-1: clear bits 2,5,8.
  - h==0: clear bits 0,1,2. h==H-1: clear bits 6,7,8.
  - Clears are cumulative (W=1 or H=1 clear both sides).
- WRITE
  - On entry: pulse dma_start for one cycle.
  - dma_last=1 in that same cycle iff h==H-1 and oc==OC-1.
  - Wait for dma_done, which may arrive in the dma_start cycle or later.
  - Then:
    - If h<H-1: h++, go to ILOAD.
    - Else if oc<OC-1: h=0, oc++, go to WLOAD.
    - Else: go to DONE.
- DONE: one cycle; layer_done=1; return to IDLE. busy drops the cycle after.
- Acks arriving outside their state are ignored. stall outside CONV is ignored.
- Counter arithmetic: unsigned CNT_W. Comparisons use the latched cfg minus 1. No wrap is possible because the index never exceeds cfg-1.
- Reset mid-layer: immediate return to IDLE with all outputs 0. Requests are dropped without completing their handshakes.
- Conv beat total per layer = OC*H*IC*W. dma_start count = OC*H.

Test Plan:
- Basic run: W=4, H=2, IC=2, OC=1, all acks tied high, stall=0 -> 16 dataflow_en cycles; 1 weight_req; 4 input_loader_req handshakes; 2 dma_start; dma_last only on the 2nd; exactly 1 layer_done.
- Mask: same config, first CONV beat -> conv_vld=9'h1B0. Beat w=3, h=1 -> 9'h01B. W=H=1 -> 9'h010.
- Stall: assert stall for 3 cycles mid-row at w=2 -> dataflow_en=0 and conv_vld=0 for 3 cycles; w_cnt holds at 2; total dataflow_en cycles still 16.
- Delayed handshakes: weight_ack after 5 cycles, input_ack after 2, dma_done after 4 -> each request stays high until its ack; counters and outputs are unchanged except the timing.
- Zero config: cfg_ic=0 with start -> layer_start, then layer_done 1 cycle later; no weight/input/dma activity.
- Reset mid-layer: rstn low during CONV at w=1 -> all outputs 0 asynchronously. After release, a new start runs the full layer correctly, and a start sent while busy is ignored.

Source files
------------

// File: rtl/conv_layer_seq_if.sv
// Control bundle between the layer scheduler / datapath side and the
// conv_layer_seq sequencer.
//
// Handshake rules:
//   start                  : one-cycle request, only honoured while busy=0.
//   weight_req/weight_ack  : weight_req is a level that stays high until
//                            weight_ack is sampled high at a rising edge.
//                            The request drops on that edge.
//   input_loader_req/input_ack : same level/ack rule as the weight pair.
//   dma_start/dma_done     : dma_start is a one-cycle pulse. The sequencer
//                            then waits for dma_done, which may already be
//                            high in the dma_start cycle.
//   Acks that arrive while no request is pending are ignored.
interface conv_layer_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] cfg_w;
  logic [CNT_W-1:0] cfg_h;
  logic [CNT_W-1:0] cfg_ic;
  logic [CNT_W-1:0] cfg_oc;
  logic             stall;
  logic             weight_ack;
  logic             input_ack;
  logic             dma_done;

  logic             layer_start;
  logic             layer_done;
  logic             busy;
  logic             dataflow_en;
  logic [8:0]       conv_vld;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] ic_cnt;
  logic [CNT_W-1:0] oc_cnt;
  logic             weight_req;
  logic             input_loader_req;
  logic             dma_start;
  logic             dma_last;

  // Scheduler / peripheral side
  modport master (
    output start, cfg_w, cfg_h, cfg_ic, cfg_oc, stall,
           weight_ack, input_ack, dma_done,
    input  layer_start, layer_done, busy, dataflow_en, conv_vld,
           w_cnt, h_cnt, ic_cnt, oc_cnt,
           weight_req, input_loader_req, dma_start, dma_last
  );

  // Sequencer side
  modport slave (
    input  start, cfg_w, cfg_h, cfg_ic, cfg_oc, stall,
           weight_ack, input_ack, dma_done,
    output layer_start, layer_done, busy, dataflow_en, conv_vld,
           w_cnt, h_cnt, ic_cnt, oc_cnt,
           weight_req, input_loader_req, dma_start, dma_last
  );
endinterface

// File: rtl/conv_layer_seq.sv
// Layer-level sequencer for a row-based 3x3, pad-1 convolution.
// Loop nest: oc (outer) -> h -> ic -> w (inner). Each oc tile fetches
// weights once, each (ic,h) row is loaded before its W conv beats, and each
// completed output row (oc,h) is handed to the output DMA.
module conv_layer_seq #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  conv_layer_seq_if.slave        bus,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_ILOAD = 3'd2,
    S_CONV  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [CNT_W-1:0] r_cfg_w;
  logic [CNT_W-1:0] r_cfg_h;
  logic [CNT_W-1:0] r_cfg_ic;
  logic [CNT_W-1:0] r_cfg_oc;
  logic [CNT_W-1:0] r_w;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_ic;
  logic [CNT_W-1:0] r_oc;
  logic             r_layer_start;
  logic             r_layer_done;
  logic             r_dma_pend;

  logic             w_accept;
  logic             w_cfg_zero;
  logic             w_beat;
  logic             w_row_done;
  logic             w_last_w;
  logic             w_last_h;
  logic             w_last_ic;
  logic             w_last_oc;
  logic [8:0]       w_mask;

  // Loop bounds compare against latched cfg-1; indices never exceed cfg-1.
  assign w_last_w   = (r_w  == r_cfg_w  - CNT_W'(1));
  assign w_last_h   = (r_h  == r_cfg_h  - CNT_W'(1));
  assign w_last_ic  = (r_ic == r_cfg_ic - CNT_W'(1));
  assign w_last_oc  = (r_oc == r_cfg_oc - CNT_W'(1));

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_cfg_zero = (bus.cfg_w == '0) || (bus.cfg_h == '0) ||
                      (bus.cfg_ic == '0) || (bus.cfg_oc == '0);
  assign w_beat     = (r_state == S_CONV) && !bus.stall;
  assign w_row_done = (r_state == S_WRITE) && bus.dma_done;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic for the loop nest
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = w_cfg_zero ? S_DONE : S_WLOAD;
      end
      S_WLOAD: begin
        if (bus.weight_ack) w_next_state = S_ILOAD;
      end
      S_ILOAD: begin
        if (bus.input_ack) w_next_state = S_CONV;
      end
      S_CONV: begin
        if (w_beat && w_last_w) w_next_state = w_last_ic ? S_WRITE : S_ILOAD;
      end
      S_WRITE: begin
        if (bus.dma_done) begin
          if (!w_last_h)      w_next_state = S_ILOAD;
          else if (!w_last_oc) w_next_state = S_WLOAD;
          else                w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Config latch and loop counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg_w  <= '0;
      r_cfg_h  <= '0;
      r_cfg_ic <= '0;
      r_cfg_oc <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_ic     <= '0;
      r_oc     <= '0;
    end else begin
      if (w_accept) begin
        r_cfg_w  <= bus.cfg_w;
        r_cfg_h  <= bus.cfg_h;
        r_cfg_ic <= bus.cfg_ic;
        r_cfg_oc <= bus.cfg_oc;
        r_w      <= '0;
        r_h      <= '0;
        r_ic     <= '0;
        r_oc     <= '0;
      end
      if (w_beat) begin
        if (w_last_w) begin
          r_w <= '0;
          if (w_last_ic) r_ic <= '0;
          else           r_ic <= r_ic + CNT_W'(1);
        end else begin
          r_w <= r_w + CNT_W'(1);
        end
      end
      if (w_row_done) begin
        if (!w_last_h) begin
          r_h <= r_h + CNT_W'(1);
        end else if (!w_last_oc) begin
          r_h  <= '0;
          r_oc <= r_oc + CNT_W'(1);
        end
      end
    end
  end

  // Registered strobes: layer_start follows the accept edge, layer_done
  // follows the DONE cycle, dma_start marks the first WRITE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_layer_start <= 1'b0;
      r_layer_done  <= 1'b0;
      r_dma_pend    <= 1'b0;
    end else begin
      r_layer_start <= w_accept;
      r_layer_done  <= (r_state == S_DONE);
      r_dma_pend    <= (w_next_state == S_WRITE) && (r_state != S_WRITE);
    end
  end

  // Tap-valid mask: drop taps that fall into the pad-1 border
  always_comb begin
    w_mask = 9'h1FF;
    if (r_w == '0) w_mask = w_mask & ~9'h049;
    if (w_last_w)  w_mask = w_mask & ~9'h124;
    if (r_h == '0) w_mask = w_mask & ~9'h007;
    if (w_last_h)  w_mask = w_mask & ~9'h1C0;
  end

  assign bus.layer_start      = r_layer_start;
  assign bus.layer_done       = r_layer_done;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.dataflow_en      = w_beat;
  assign bus.conv_vld         = w_beat ? w_mask : 9'h000;
  assign bus.w_cnt            = r_w;
  assign bus.h_cnt            = r_h;
  assign bus.ic_cnt           = r_ic;
  assign bus.oc_cnt           = r_oc;
  assign bus.weight_req       = (r_state == S_WLOAD);
  assign bus.input_loader_req = (r_state == S_ILOAD);
  assign bus.dma_start        = r_dma_pend;
  assign bus.dma_last         = r_dma_pend && w_last_h && w_last_oc;
  assign o_dbg_state          = r_state;

endmodule
